// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter
//
// Shares the single read port of the instruction BRAM between N_REQ fetch
// units using round-robin arbitration and steers each read response back to
// the requester that issued it. Also owns the BRAM write port: a loader
// programs the memory while reads are fenced off by a RUN/DRAIN/LOAD
// controller. Reset lands in LOAD because the memory is unprogrammed.
//
// Optional feature macro: BRAM_ARB_RSP_REG_EN
//   defined   : rsp_valid/rsp_data registered one extra stage (latency 2)
//   undefined : rsp_data = bram_r_data directly, latency 1
//
// Ports
//   clk, rst                        clock, asynchronous active-low reset
//   req_valid/req_addr/req_ready    per-requester read request, one-hot grant
//   rsp_valid/rsp_data              one-hot response strobe and word
//   ld_start/ld_done                enter / leave load mode (pulses)
//   ld_valid/ld_ready/ld_addr/ld_data  loader write handshake
//   loading                         high in DRAIN or LOAD
//   bram_r_*                        BRAM read port (1-cycle registered read)
//   bram_w_*                        BRAM write port
module bram_read_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [WIDTH-1:0]            rsp_data,
    input  logic                        ld_start,
    input  logic                        ld_done,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [ADDR_WIDTH-1:0]       ld_addr,
    input  logic [WIDTH-1:0]            ld_data,
    output logic                        loading,
    output logic                        bram_r_valid,
    output logic [ADDR_WIDTH-1:0]       bram_r_addr,
    input  logic [WIDTH-1:0]            bram_r_data,
    output logic                        bram_w_valid,
    output logic [ADDR_WIDTH-1:0]       bram_w_addr,
    output logic [WIDTH-1:0]            bram_w_data
);

    localparam int RR_W = $clog2(N_REQ);
    localparam logic [RR_W-1:0] RR_LAST = RR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [RR_W-1:0]    rr_q, rr_d;
    logic [N_REQ-1:0]   tag_p0_q, tag_p0_d;
    logic [N_REQ-1:0]   grant;
    logic [RR_W-1:0]    gidx;
    logic [RR_W-1:0]    idx;
    logic               found;
    logic               pipe_empty;

    // Round-robin search starting at rr_q; the first valid requester wins.
    // A cycle carrying ld_start grants nothing so DRAIN starts from a
    // known set of in-flight reads.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        if (state_q == ST_RUN && !ld_start) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = RR_W'((int'(rr_q) + k) % N_REQ);
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    gidx  = idx;
                end
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    always_comb begin
        bram_r_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                bram_r_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign req_ready    = grant;
    assign bram_r_valid = found;
    assign ld_ready     = (state_q == ST_LOAD);
    assign loading      = (state_q != ST_RUN);
    assign bram_w_valid = ld_ready & ld_valid;
    assign bram_w_addr  = ld_addr;
    assign bram_w_data  = ld_data;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        tag_p0_d = grant;
        if (found) begin
            rr_d = (gidx == RR_LAST) ? '0 : gidx + RR_W'(1);
        end
        case (state_q)
            ST_RUN:   if (ld_start)   state_d = ST_DRAIN;
            // No grants are issued here, so the current tag registers hold
            // every outstanding read.
            ST_DRAIN: if (pipe_empty) state_d = ST_LOAD;
            ST_LOAD:  if (ld_done)    state_d = ST_RUN;
            default:                  state_d = ST_LOAD;
        endcase
    end

    // Stage 0: grant captured alongside the BRAM read issue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_LOAD;
            rr_q     <= '0;
            tag_p0_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            tag_p0_q <= tag_p0_d;
        end
    end

`ifdef BRAM_ARB_RSP_REG_EN
    logic [N_REQ-1:0] tag_p1_q, tag_p1_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    always_comb begin
        tag_p1_d   = tag_p0_q;
        rsp_data_d = (|tag_p0_q) ? bram_r_data : rsp_data_q;
    end

    // Stage 1: BRAM word and its tag re-registered before leaving the block
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_p1_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            tag_p1_q   <= tag_p1_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign pipe_empty = ~(|tag_p0_q) & ~(|tag_p1_q);
    assign rsp_valid  = tag_p1_q;
    assign rsp_data   = rsp_data_q;
`else
    assign pipe_empty = ~(|tag_p0_q);
    assign rsp_valid  = tag_p0_q;
    assign rsp_data   = bram_r_data;
`endif

endmodule

// File: tb/tb_bram_read_arbiter.sv
module tb_bram_read_arbiter;

`ifdef BRAM_ARB_RSP_REG_EN
    localparam int LAT       = 2;
    localparam int DRAIN_EXP = 2;
`else
    localparam int LAT       = 1;
    localparam int DRAIN_EXP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [39:0] req_addr = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [63:0] rsp_data;
    logic        ld_start = 1'b0;
    logic        ld_done = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [9:0]  ld_addr = '0;
    logic [63:0] ld_data = '0;
    logic        loading;
    logic        bram_r_valid;
    logic [9:0]  bram_r_addr;
    logic [63:0] bram_r_data = '0;
    logic        bram_w_valid;
    logic [9:0]  bram_w_addr;
    logic [63:0] bram_w_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bram_read_arbiter #(.N_REQ(4), .WIDTH(64), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ld_start(ld_start), .ld_done(ld_done),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data),
        .loading(loading),
        .bram_r_valid(bram_r_valid), .bram_r_addr(bram_r_addr), .bram_r_data(bram_r_data),
        .bram_w_valid(bram_w_valid), .bram_w_addr(bram_w_addr), .bram_w_data(bram_w_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM with a 1-cycle registered read
    logic [63:0] mem [0:1023];
    always @(posedge clk) begin
        if (bram_w_valid) mem[bram_w_addr] <= bram_w_data;
        if (bram_r_valid) bram_r_data <= mem[bram_r_addr];
    end

    // Expected memory contents, written only by the bench's own loader stimulus
    logic [63:0] exp_mem [0:1023];

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
        int          due;
    } rsp_t;
    rsp_t sb[$];

    // Scoreboard: push on each accepted request, compare at the due cycle
    always @(negedge clk) begin
        rsp_t it;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL rsp_missed: response due at cycle %0d not seen (now %0d)", sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            checks++;
            if (rsp_valid !== sb[0].tag || rsp_data !== sb[0].data) begin
                errors++;
                $display("FAIL rsp: got valid=%b data=%h, expected valid=%b data=%h",
                         rsp_valid, rsp_data, sb[0].tag, sb[0].data);
            end
            void'(sb.pop_front());
        end else if (rsp_valid !== 4'b0000) begin
            checks++; errors++;
            $display("FAIL rsp_spurious: got valid=%b, expected 0000 at cycle %0d", rsp_valid, cyc);
        end
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                it.tag  = 4'b0001 << i;
                it.data = exp_mem[req_addr[i*10 +: 10]];
                it.due  = cyc + LAT;
                sb.push_back(it);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] vld;
        logic [3:0] rdy;
    } vec_t;
    vec_t tbl [12];

    int drain;

    initial begin
        // Arbitration vectors; the pointer enters this table at 3
        tbl[0]  = '{vld: 4'b1111, rdy: 4'b1000};  // rr 3 -> 0
        tbl[1]  = '{vld: 4'b1111, rdy: 4'b0001};  // rr 0 -> 1
        tbl[2]  = '{vld: 4'b1111, rdy: 4'b0010};  // rr 1 -> 2
        tbl[3]  = '{vld: 4'b1111, rdy: 4'b0100};  // rr 2 -> 3
        tbl[4]  = '{vld: 4'b1111, rdy: 4'b1000};  // rr 3 -> 0
        tbl[5]  = '{vld: 4'b1111, rdy: 4'b0001};  // rr 0 -> 1
        tbl[6]  = '{vld: 4'b0101, rdy: 4'b0100};  // rr 1 -> 3
        tbl[7]  = '{vld: 4'b0011, rdy: 4'b0001};  // rr 3 wraps -> 1
        tbl[8]  = '{vld: 4'b0010, rdy: 4'b0010};  // rr 1 -> 2
        tbl[9]  = '{vld: 4'b0000, rdy: 4'b0000};  // rr stays 2
        tbl[10] = '{vld: 4'b1001, rdy: 4'b1000};  // rr 2 -> 0
        tbl[11] = '{vld: 4'b0110, rdy: 4'b0010};  // rr 0 -> 2, then 2 -> 3 below

        // Reset with every requester asking: nothing may be granted
        req_addr  = {10'd3, 10'd2, 10'd1, 10'd0};
        req_valid = 4'b1111;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_bram_r_valid", bram_r_valid, 0);
        chk("rst_bram_w_valid", bram_w_valid, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_loading", loading, 1);
        next_cyc();
        next_cyc();
        rst = 1'b1;

        // Load 0xA0..0xA3 at 0..3 while requests are pending
        for (int a = 0; a < 4; a++) begin
            ld_valid = 1'b1;
            ld_addr  = 10'(a);
            ld_data  = 64'hA0 + 64'(a);
            exp_mem[a] = 64'hA0 + 64'(a);
            @(negedge clk);
            chk("load_ld_ready", ld_ready, 1);
            chk("load_w_valid", bram_w_valid, 1);
            chk("load_w_addr", bram_w_addr, 10'(a));
            chk("load_req_ready", req_ready, 0);
            next_cyc();
        end
        ld_valid  = 1'b0;
        ld_done   = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("ld_done_loading", loading, 1);
        chk("ld_done_req_ready", req_ready, 0);
        next_cyc();
        ld_done = 1'b0;
        @(negedge clk);
        chk("run_loading", loading, 0);
        chk("run_ld_ready", ld_ready, 0);

        // Requester 2 alone reads address 1
        next_cyc();
        req_addr[20 +: 10] = 10'd1;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_req_ready", req_ready, 4'b0100);
        chk("single_r_valid", bram_r_valid, 1);
        chk("single_r_addr", bram_r_addr, 10'd1);
        next_cyc();
        req_valid = 4'b0000;
        req_addr  = {10'd3, 10'd2, 10'd1, 10'd0};
        next_cyc();
        next_cyc();

        // Table-driven arbitration, addresses equal requester index
        for (int v = 0; v < 12; v++) begin
            req_valid = tbl[v].vld;
            @(negedge clk);
            chk($sformatf("tbl%0d_req_ready", v), req_ready, tbl[v].rdy);
            chk($sformatf("tbl%0d_r_valid", v), bram_r_valid, (tbl[v].rdy != 0));
            next_cyc();
        end
        req_valid = 4'b0100;
        @(negedge clk);
        chk("tbl_last_req_ready", req_ready, 4'b0100);
        next_cyc();

        // Grant to 3, then ld_start with everyone still valid
        req_valid = 4'b1111;
        @(negedge clk);
        chk("drain_pre_grant", req_ready, 4'b1000);
        next_cyc();
        ld_start = 1'b1;
        @(negedge clk);
        chk("ld_start_req_ready", req_ready, 0);
        chk("ld_start_r_valid", bram_r_valid, 0);
        chk("ld_start_loading", loading, 0);
        next_cyc();
        ld_start = 1'b0;
        drain = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ld_ready) break;
            chk("drain_req_ready", req_ready, 0);
            chk("drain_loading", loading, 1);
            drain++;
            next_cyc();
        end
        chk("drain_len", drain, DRAIN_EXP);

        // Write coincident with ld_done
        req_valid = 4'b0000;
        ld_valid  = 1'b1;
        ld_done   = 1'b1;
        ld_addr   = 10'd5;
        ld_data   = 64'h55;
        exp_mem[5] = 64'h55;
        #1;
        chk("done_w_valid", bram_w_valid, 1);
        chk("done_w_addr", bram_w_addr, 10'd5);
        chk("done_w_data", bram_w_data, 64'h55);
        next_cyc();
        ld_valid = 1'b0;
        ld_done  = 1'b0;
        @(negedge clk);
        chk("reload_loading", loading, 0);
        next_cyc();
        req_addr[10 +: 10] = 10'd5;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("addr5_req_ready", req_ready, 4'b0010);
        chk("addr5_r_addr", bram_r_addr, 10'd5);
        next_cyc();
        req_valid = 4'b0000;
        req_addr  = {10'd3, 10'd2, 10'd1, 10'd0};
        for (int k = 0; k < 3; k++) next_cyc();

        // Reset one cycle after a grant: the response must vanish
        req_valid = 4'b0001;
        @(negedge clk);
        chk("prerst_req_ready", req_ready, 4'b0001);
        next_cyc();
        req_valid = 4'b0000;
        rst = 1'b0;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_rsp_valid", rsp_valid, 0);
            chk("midrst_loading", loading, 1);
            chk("midrst_ld_ready", ld_ready, 1);
            next_cyc();
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("postrst_rsp_valid", rsp_valid, 0);
            next_cyc();
        end
        ld_done = 1'b1;
        next_cyc();
        ld_done = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("postrst_rr0_grant", req_ready, 4'b0001);
        next_cyc();
        req_valid = 4'b0000;
        for (int k = 0; k < 4; k++) next_cyc();
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
